mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//  Memory-mapped I/O responder on the CPU data bus (MADDR/DATA_O/WRITE/READ -> read data).
//  Decodes a 16-byte window at BASE; serves LEDs, synchronised switches, a key-press event FIFO and an interval timer.
//  Sits beside the data RAM. Top level selects RD_DATA over RAM q whenever RD_HIT=1.
//  Same 1-cycle read latency as the synchronous RAM, so the CPU sees no timing difference.
// PARAMETERS
//  BASE        8'hF0  window base; hit when MADDR[7:4]==BASE[7:4]; BASE[3:0] must be 0
//  FIFO_DEPTH  4      key-event FIFO entries; power of 2, 2..16
//  SYNC_STAGES 2      flops in the SW/KEY synchronisers; >=2
// PORTS
//  CLK      in   1  system clock, rising edge
//  RST      in   1  synchronous reset, active-high
//  MADDR    in   8  CPU address
//  DATA_O   in   8  CPU write data
//  WRITE    in   1  CPU write strobe, 1 cycle per access
//  READ     in   1  CPU read strobe, 1 cycle per access
//  SW       in   8  board switches, asynchronous
//  KEY      in   4  board keys, asynchronous, active-low (0 = pressed)
//  RD_DATA  out  8  registered read data, valid the cycle after READ
//  RD_HIT   out  1  registered; 1 the cycle after a READ that hit the window
//  LED_O    out  8  LED register contents
//  IRQ      out  1  STATUS.tflag AND CTRL.ie
// BEHAVIOUR
//  Reset: RD_DATA=0, RD_HIT=0, LED_O=0, IRQ=0, FIFO empty, ovf=0, tflag=0, CNT=0, CMP=0, CTRL=0.
//    Synchroniser flops reset to 1 (KEY idle) / 0 (SW).
//  Register map (offset = MADDR[3:0]):
//    0x0 LED    RW
//    0x1 SW     RO  synchronised switches
//    0x2 KEYEV  RO  pops FIFO: [7]=valid, [3:0]=key mask; reads 0x00 when empty, no pop
//    0x3 STATUS [0]=empty [1]=full [2]=ovf [3]=tflag; W1C on [2],[3]; other bits read 0
//    0x4 CMP    RW
//    0x5 CNT    RO
//    0x6 CTRL   RW [0]=en [1]=autoreload [2]=ie
//    others     read 0, writes ignored
//  Writes: register updates at the clock edge ending the WRITE cycle.
//  Reads: RD_DATA/RD_HIT update at the edge ending the READ cycle; a miss drives RD_HIT=0, RD_DATA holds.
//  READ and WRITE both high: WRITE wins, no read response, no pop.
//  Key events: falling edge of any synchronised KEY bit -> push {1'b1,3'b0,mask of bits that fell this cycle}.
//    Multiple simultaneous falls -> one entry.
//  FIFO: push when full drops the event and sets ovf (sticky until W1C).
//    Push + pop same cycle: both take effect. When full, the pop frees the slot and the push succeeds, no ovf.
//    Pointers wrap modulo FIFO_DEPTH.
//  Timer (en=1): CNT increments every cycle. On the edge where CNT==CMP: tflag<=1.
//    autoreload=1 -> CNT<=0, keeps running; autoreload=0 -> en<=0, CNT holds.
//    CNT wraps 0xFF->0x00. CMP written while running takes effect next compare.
//    Writing CTRL.en 0->1 clears CNT.
//  Set vs clear: a tflag set and a W1C in the same cycle -> set wins. Same rule for ovf.
//  RST asserted mid-operation: all state returns to reset values on the next edge; a pending read response is dropped.
// CONFIGURATION
//  MMIO_TIMER_EN defined: timer present as described.
//  Not defined: CMP/CNT/CTRL read 0, writes ignored, tflag and IRQ tied 0, no timer flops.
// STRUCTURE
//  Package mmio_pkg holds:
//    register offset localparams (OFF_LED..OFF_CTRL)
//    STATUS/CTRL bit-index constants
//    KEYEV valid-bit index
//  Sub-module key_event_fifo (params WIDTH=4, DEPTH): push/pop/full/empty/count.
//    Sync flops, edge detect, decode and timer stay in mmio_responder.
// TESTING
//  1. Reset, WRITE 0xF0<=0xA5, READ 0xF0 -> LED_O=0xA5; next cycle RD_HIT=1, RD_DATA=0xA5. READ 0x10 -> RD_HIT=0.
//  2. KEY[1] 1->0 held 5 cycles; after SYNC_STAGES+1 cycles READ 0xF2 -> 0x82. Second read -> 0x00, STATUS.empty=1.
//  3. Five presses with no reads (DEPTH=4) -> STATUS=0x06. W1C 0x04 -> STATUS=0x02. Pop+push same cycle when full -> still full, ovf=0.
//  4. CMP=3, CTRL=0x07 -> tflag and IRQ high 4 cycles after the write, CNT reloads to 0.
//     Then CTRL=0x01 -> en clears at the next compare, CNT holds 3.
//  5. RST pulsed while FIFO holds 2 entries and the timer runs -> STATUS=0x01, CNT=0, LED_O=0, RD_HIT=0.
//  6. Without MMIO_TIMER_EN: WRITE 0xF4<=0x05, READ 0xF4 -> 0x00; IRQ stays 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets and bit indices for the MMIO responder window
package mmio_pkg;

    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_SW     = 4'h1;
    localparam logic [3:0] OFF_KEYEV  = 4'h2;
    localparam logic [3:0] OFF_STATUS = 4'h3;
    localparam logic [3:0] OFF_CMP    = 4'h4;
    localparam logic [3:0] OFF_CNT    = 4'h5;
    localparam logic [3:0] OFF_CTRL   = 4'h6;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_TFLAG = 3;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    localparam int KEYEV_VALID = 7;

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - small key-event FIFO; a pop frees a slot for a same-cycle push when full
module key_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - 16-byte MMIO window: LEDs, switches, key events, timer (MMIO_TIMER_EN)
module mmio_responder #(
    parameter logic [7:0] BASE        = 8'hF0,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] maddr,
    input  logic [7:0] data_o,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] sw,
    input  logic [3:0] key,
    output logic [7:0] rd_data,
    output logic       rd_hit,
    output logic [7:0] led_o,
    output logic       irq
);

    import mmio_pkg::*;

    logic [SYNC_STAGES-1:0][7:0] sw_sync;
    logic [SYNC_STAGES-1:0][3:0] key_sync;
    logic [3:0] key_last;
    logic [3:0] key_fell;

    logic       hit;
    logic [3:0] offset;
    logic       wr_hit;
    logic       rd_now;
    logic       w1c_sel;

    logic       fifo_push;
    logic       fifo_pop;
    logic [3:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

    logic       ovf;
    logic [7:0] rd_mux;

    logic [7:0] cnt;
    logic [7:0] cmp;
    logic [2:0] ctrl;
    logic       tflag;

    // keys idle high, so their synchronisers reset to 1 to avoid a spurious event
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync  <= '0;
            key_sync <= '1;
            key_last <= 4'hF;
        end else begin
            sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw};
            key_sync <= {key_sync[SYNC_STAGES-2:0], key};
            key_last <= key_sync[SYNC_STAGES-1];
        end
    end

    assign key_fell = key_last & ~key_sync[SYNC_STAGES-1];

    assign hit     = (maddr[7:4] == BASE[7:4]);
    assign offset  = maddr[3:0];
    assign wr_hit  = write & hit;
    assign rd_now  = read & ~write & hit;
    assign w1c_sel = wr_hit & (offset == OFF_STATUS);

    assign fifo_push = |key_fell;
    assign fifo_pop  = rd_now & (offset == OFF_KEYEV) & ~fifo_empty;

    key_event_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (key_fell),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= (fifo_push & fifo_full & ~fifo_pop) | (ovf & ~(w1c_sel & data_o[ST_OVF]));
        end
    end

`ifdef MMIO_TIMER_EN
    logic tflag_set;
    assign tflag_set = ctrl[CTRL_EN] & (cnt == cmp);

    // register writes are applied after the timer step so software overrides it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            cmp   <= '0;
            ctrl  <= '0;
            tflag <= 1'b0;
        end else begin
            if (ctrl[CTRL_EN]) begin
                if (cnt == cmp) begin
                    if (ctrl[CTRL_AR]) begin
                        cnt <= '0;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
            if (wr_hit && offset == OFF_CMP) begin
                cmp <= data_o;
            end
            if (wr_hit && offset == OFF_CTRL) begin
                ctrl <= data_o[2:0];
                if (data_o[CTRL_EN] && !ctrl[CTRL_EN]) begin
                    cnt <= '0;
                end
            end
            tflag <= tflag_set | (tflag & ~(w1c_sel & data_o[ST_TFLAG]));
        end
    end

    assign irq = tflag & ctrl[CTRL_IE];
`else
    assign cnt   = '0;
    assign cmp   = '0;
    assign ctrl  = '0;
    assign tflag = 1'b0;
    assign irq   = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_LED:    rd_mux = led_o;
            OFF_SW:     rd_mux = sw_sync[SYNC_STAGES-1];
            OFF_KEYEV:  rd_mux = fifo_empty ? 8'h00 : {1'b1, 3'b000, fifo_dout};
            OFF_STATUS: rd_mux = {4'b0000, tflag, ovf, fifo_full, fifo_empty};
            OFF_CMP:    rd_mux = cmp;
            OFF_CNT:    rd_mux = cnt;
            OFF_CTRL:   rd_mux = {5'b00000, ctrl};
            default:    rd_mux = '0;
        endcase
    end

    // a miss keeps the previous read data so the top-level mux sees a stable value
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_hit  <= 1'b0;
            led_o   <= '0;
        end else begin
            rd_hit <= rd_now;
            if (rd_now) begin
                rd_data <= rd_mux;
            end
            if (wr_hit && offset == OFF_LED) begin
                led_o <= data_o;
            end
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - directed scoreboard bench for mmio_responder
module tb_mmio_responder;

    logic       clk;
    logic       rst;
    logic [7:0] maddr;
    logic [7:0] data_o;
    logic       write;
    logic       read;
    logic [7:0] sw;
    logic [3:0] key;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic [7:0] led_o;
    logic       irq;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    mmio_responder dut (
        .clk     (clk),
        .rst     (rst),
        .maddr   (maddr),
        .data_o  (data_o),
        .write   (write),
        .read    (read),
        .sw      (sw),
        .key     (key),
        .rd_data (rd_data),
        .rd_hit  (rd_hit),
        .led_o   (led_o),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        maddr  = addr;
        data_o = data;
        write  = 1'b1;
        tick();
        write  = 1'b0;
    endtask

    // for a miss, exp_data is the value rd_data must still hold
    task automatic do_read(input logic [7:0] addr, input logic [7:0] exp_data, input string tag);
        logic hit_exp;
        logic [7:0] e;
        hit_exp = (addr[7:4] == 4'hF);
        if (hit_exp) exp_q.push_back(exp_data);
        maddr = addr;
        read  = 1'b1;
        tick();
        read  = 1'b0;
        check({tag, ".hit"}, {7'd0, rd_hit}, {7'd0, hit_exp});
        if (hit_exp) e = exp_q.pop_front();
        else         e = exp_data;
        check(tag, rd_data, e);
    endtask

    task automatic press(input logic [3:0] k);
        key = k;
        repeat (4) tick();
        key = 4'hF;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1; maddr = '0; data_o = '0; write = 1'b0; read = 1'b0;
        sw = 8'h00; key = 4'hF;
        repeat (3) tick();
        check("rst.rd_data", rd_data, 8'h00);
        check("rst.rd_hit", {7'd0, rd_hit}, 8'h00);
        check("rst.led", led_o, 8'h00);
        check("rst.irq", {7'd0, irq}, 8'h00);
        rst = 1'b0;
        tick();

        do_write(8'hF0, 8'hA5);
        check("led.write", led_o, 8'hA5);
        do_read(8'hF0, 8'hA5, "led.read");
        do_read(8'h10, 8'hA5, "miss.read");
        do_read(8'hF9, 8'h00, "unmapped.read");
        do_write(8'hF9, 8'h33);
        check("unmapped.write", led_o, 8'hA5);

        maddr = 8'hF0; data_o = 8'h11; read = 1'b1; write = 1'b1;
        tick();
        read = 1'b0; write = 1'b0;
        check("rw.rd_hit", {7'd0, rd_hit}, 8'h00);
        check("rw.led", led_o, 8'h11);

        sw = 8'h3C;
        repeat (3) tick();
        do_read(8'hF1, 8'h3C, "sw.read");

        key = 4'b1101;
        repeat (5) tick();
        key = 4'hF;
        repeat (4) tick();
        do_read(8'hF2, 8'h82, "key1.pop");
        do_read(8'hF2, 8'h00, "key1.empty");
        do_read(8'hF3, 8'h01, "key1.status");

        press(4'b1110);
        press(4'b1101);
        press(4'b1011);
        press(4'b0011);
        press(4'b1100);
        do_read(8'hF3, 8'h06, "ovf.status");
        do_write(8'hF3, 8'h04);
        do_read(8'hF3, 8'h02, "ovf.w1c");

        key = 4'b1010;
        tick();
        tick();
        do_read(8'hF2, 8'h81, "pushpop.pop");
        key = 4'hF;
        repeat (4) tick();
        do_read(8'hF3, 8'h02, "pushpop.status");
        do_read(8'hF2, 8'h82, "drain0");
        do_read(8'hF2, 8'h84, "drain1");
        do_read(8'hF2, 8'h8C, "drain2");
        do_read(8'hF2, 8'h85, "drain3");
        do_read(8'hF3, 8'h01, "drain.status");

`ifdef MMIO_TIMER_EN
        do_write(8'hF4, 8'h03);
        do_write(8'hF6, 8'h07);
        repeat (3) tick();
        check("tmr.irq_early", {7'd0, irq}, 8'h00);
        tick();
        check("tmr.irq", {7'd0, irq}, 8'h01);
        do_read(8'hF5, 8'h00, "tmr.reload");
        do_write(8'hF6, 8'h01);
        repeat (6) tick();
        do_read(8'hF5, 8'h03, "tmr.hold");
        do_read(8'hF6, 8'h00, "tmr.en_clr");
        do_read(8'hF3, 8'h09, "tmr.status");
        check("tmr.irq_off", {7'd0, irq}, 8'h00);
        do_write(8'hF3, 8'h08);
        do_read(8'hF3, 8'h01, "tmr.w1c");
`else
        do_write(8'hF4, 8'h05);
        do_read(8'hF4, 8'h00, "notmr.cmp");
        do_write(8'hF6, 8'h07);
        do_read(8'hF6, 8'h00, "notmr.ctrl");
        repeat (8) tick();
        do_read(8'hF5, 8'h00, "notmr.cnt");
        check("notmr.irq", {7'd0, irq}, 8'h00);
`endif

        press(4'b1110);
        press(4'b0111);
`ifdef MMIO_TIMER_EN
        do_write(8'hF4, 8'h80);
        do_write(8'hF6, 8'h01);
`endif
        do_write(8'hF0, 8'h5A);
        do_read(8'hF1, 8'h3C, "pre_rst.read");
        maddr = 8'hF0; read = 1'b1; rst = 1'b1;
        tick();
        read = 1'b0; rst = 1'b0;
        check("midrst.rd_hit", {7'd0, rd_hit}, 8'h00);
        check("midrst.rd_data", rd_data, 8'h00);
        check("midrst.led", led_o, 8'h00);
        check("midrst.irq", {7'd0, irq}, 8'h00);
        repeat (3) tick();
        do_read(8'hF3, 8'h01, "midrst.status");
        do_read(8'hF5, 8'h00, "midrst.cnt");
        do_read(8'hF6, 8'h00, "midrst.ctrl");
        do_read(8'hF2, 8'h00, "midrst.keyev");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
